// File: rtl/prog_loader.sv
// Host program loader: parses IMEM/DMEM/GO packets from a word stream into core memory writes and launch control.
// Writes land 1 cycle after accept; s_ready drops only for the single LAUNCH cycle and while held in reset.
module prog_loader #(
  parameter int          RV_BIT_NUM = 32,
  parameter int          CNT_W      = 24,
  parameter logic [7:0]  TYPE_IMEM  = 8'h49,
  parameter logic [7:0]  TYPE_DMEM  = 8'h44,
  parameter logic [7:0]  TYPE_GO    = 8'h47
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [RV_BIT_NUM-1:0] s_data,
  output logic                  s_ready,
  output logic [RV_BIT_NUM-1:0] imem_wr_addr,
  output logic [RV_BIT_NUM-1:0] imem_wr_data,
  output logic                  imem_wr_valid,
  output logic [RV_BIT_NUM-1:0] dmem_wr_addr,
  output logic [RV_BIT_NUM-1:0] dmem_wr_data,
  output logic                  dmem_wr_valid,
  output logic                  pc_valid_o,
  output logic [RV_BIT_NUM-1:0] pc_start_minus4,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] GOPC   = 3'd3;
  localparam logic [2:0] LAUNCH = 3'd4;
  localparam logic [2:0] RUN    = 3'd5;

  typedef struct packed {
    logic [7:0]  pktType;
    logic [23:0] pktCnt;
  } hdr_t;

  hdr_t                  hdr;
  logic [CNT_W-1:0]      hdrCnt;
  logic [2:0]            state;
  logic                  readyOk;
  logic                  accept;
  logic                  isDmem;
  logic [CNT_W-1:0]      remaining;
  logic [RV_BIT_NUM-1:0] addr;
  logic [RV_BIT_NUM-1:0] wrAddr;
  logic [RV_BIT_NUM-1:0] wrData;
  logic                  imemVld;
  logic                  dmemVld;
  logic                  pcValid;
  logic [RV_BIT_NUM-1:0] pcStartM4;
  logic                  err;

  assign hdr    = s_data[31:0];
  assign hdrCnt = hdr.pktCnt[CNT_W-1:0];

  // readyOk keeps the stream stalled until the first edge after reset release.
  assign s_ready = readyOk && (state != LAUNCH);
  assign accept  = s_valid && s_ready;
  assign busy_o  = (state != IDLE) && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      readyOk   <= 1'b0;
      isDmem    <= 1'b0;
      remaining <= '0;
      addr      <= '0;
      wrAddr    <= '0;
      wrData    <= '0;
      imemVld   <= 1'b0;
      dmemVld   <= 1'b0;
      pcValid   <= 1'b0;
      pcStartM4 <= '0;
      err       <= 1'b0;
    end else begin
      readyOk <= 1'b1;
      imemVld <= 1'b0;
      dmemVld <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            // Any header seen while running stops the core first.
            pcValid <= 1'b0;
            if (hdr.pktType == TYPE_IMEM || hdr.pktType == TYPE_DMEM) begin
              isDmem    <= (hdr.pktType == TYPE_DMEM);
              remaining <= hdrCnt;
              state     <= ADDR;
            end else if (hdr.pktType == TYPE_GO) begin
              state <= GOPC;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        ADDR: begin
          if (accept) begin
            addr  <= s_data;
            state <= (remaining == '0) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            wrAddr    <= addr;
            wrData    <= s_data;
            imemVld   <= !isDmem;
            dmemVld   <= isDmem;
            addr      <= addr + RV_BIT_NUM'(4);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1))
              state <= IDLE;
          end
        end
        GOPC: begin
          if (accept) begin
            pcStartM4 <= s_data - RV_BIT_NUM'(4);
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          pcValid <= 1'b1;
          state   <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_wr_addr    = wrAddr;
  assign imem_wr_data    = wrData;
  assign imem_wr_valid   = imemVld;
  assign dmem_wr_addr    = wrAddr;
  assign dmem_wr_data    = wrData;
  assign dmem_wr_valid   = dmemVld;
  assign pc_valid_o      = pcValid;
  assign pc_start_minus4 = pcStartM4;
  assign err_o           = err;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: packets built from a generator that also predicts the memory writes and launch state.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] imem_wr_addr, imem_wr_data, dmem_wr_addr, dmem_wr_data;
  logic        imem_wr_valid, dmem_wr_valid;
  logic        pc_valid_o;
  logic [31:0] pc_start_minus4;
  logic        busy_o, err_o;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data), .imem_wr_valid(imem_wr_valid),
    .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data), .dmem_wr_valid(dmem_wr_valid),
    .pc_valid_o(pc_valid_o), .pc_start_minus4(pc_start_minus4),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          dmem;
    longint      due;
  } wr_t;

  wr_t    expQ[$];
  wr_t    mon;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     expErr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the oldest predicted write, in the cycle right after its accept.
  always @(negedge clk) begin
    if (imem_wr_valid && dmem_wr_valid) begin
      checks++; errors++;
      $display("FAIL both_strobes cyc=%0d imem=1 dmem=1 expected at most one", cyc);
    end
    if (imem_wr_valid || dmem_wr_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL spurious_write cyc=%0d imem=%0b dmem=%0b addr=%h data=%h", cyc,
                 imem_wr_valid, dmem_wr_valid, imem_wr_addr, imem_wr_data);
      end else begin
        mon = expQ.pop_front();
        if (dmem_wr_valid !== mon.dmem || cyc != mon.due ||
            (mon.dmem ? dmem_wr_addr : imem_wr_addr) !== mon.addr ||
            (mon.dmem ? dmem_wr_data : imem_wr_data) !== mon.data) begin
          errors++;
          $display("FAIL write cyc=%0d dmem=%0b addr=%h data=%h ; expected cyc=%0d dmem=%0b addr=%h data=%h",
                   cyc, dmem_wr_valid, mon.dmem ? dmem_wr_addr : imem_wr_addr,
                   mon.dmem ? dmem_wr_data : imem_wr_data, mon.due, mon.dmem, mon.addr, mon.data);
        end
      end
    end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
      checks++; errors++;
      mon = expQ.pop_front();
      $display("FAIL missing_write cyc=%0d strobes low ; expected addr=%h data=%h dmem=%0b",
               cyc, mon.addr, mon.data, mon.dmem);
    end
  end

  // Presents one word (after gap idle cycles) and returns on the negedge following its accept.
  task automatic sendWord(input logic [31:0] w, input int gap, input bit isData,
                          input logic [31:0] a, input bit dm);
    int guard;
    s_valid = 1'b0;
    repeat (gap) begin
      s_data = $urandom;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = w;
    guard   = 0;
    while (s_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL accept_timeout word=%h s_ready=%b expected 1 within 20 cycles", w, s_ready);
      s_valid = 1'b0;
      return;
    end
    if (isData) expQ.push_back('{a, w, dm, cyc + 1});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic sendPacket(input bit dm, input logic [31:0] base, input int n, input int gmax);
    logic [31:0] a;
    logic [31:0] h;
    a = base;
    h = {(dm ? 8'h44 : 8'h49), 24'(n)};
    sendWord(h, $urandom_range(0, gmax), 1'b0, '0, 1'b0);
    checks++;
    if (pc_valid_o !== 1'b0 || err_o !== expErr) begin
      errors++;
      $display("FAIL hdr_state pc_valid=%b err=%b ; expected pc_valid=0 err=%b", pc_valid_o, err_o, expErr);
    end
    sendWord(base, $urandom_range(0, gmax), 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      sendWord($urandom, $urandom_range(0, gmax), 1'b1, a, dm);
      a = a + 32'd4;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_packet busy=%b expected 0", busy_o);
    end
  endtask

  task automatic sendGo(input logic [31:0] pc, input int gmax);
    logic [31:0] expPc;
    expPc = pc - 32'd4;
    sendWord(32'h4700_0000 | 32'($urandom_range(0, 255)), $urandom_range(0, gmax), 1'b0, '0, 1'b0);
    sendWord(pc, $urandom_range(0, gmax), 1'b0, '0, 1'b0);
    checks++;
    if (s_ready !== 1'b0 || pc_valid_o !== 1'b0 || pc_start_minus4 !== expPc || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL launch_cycle s_ready=%b pc_valid=%b pc_m4=%h busy=%b ; expected 0 0 %h 1",
               s_ready, pc_valid_o, pc_start_minus4, busy_o, expPc);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || pc_valid_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL run_entry s_ready=%b pc_valid=%b busy=%b ; expected 1 1 0", s_ready, pc_valid_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_wr_valid !== 0 || dmem_wr_valid !== 0 || pc_valid_o !== 0 ||
        pc_start_minus4 !== 0 || busy_o !== 0 || err_o !== 0) begin
      errors++;
      $display("FAIL reset_values imem=%b dmem=%b pcv=%b pcm4=%h busy=%b err=%b ; expected all 0",
               imem_wr_valid, dmem_wr_valid, pc_valid_o, pc_start_minus4, busy_o, err_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset s_ready=%b expected 1", s_ready);
    end
  endtask

  task automatic test_imem_burst();
    sendWord(32'h4900_0003, 0, 1'b0, '0, 1'b0);
    sendWord(32'h0000_0100, 0, 1'b0, '0, 1'b0);
    sendWord(32'h0000_000A, 0, 1'b1, 32'h100, 1'b0);
    sendWord(32'h0000_000B, 0, 1'b1, 32'h104, 1'b0);
    sendWord(32'h0000_000C, 0, 1'b1, 32'h108, 1'b0);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL imem_burst_busy busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_dmem_gaps();
    sendWord(32'h4400_0002, 2, 1'b0, '0, 1'b0);
    sendWord(32'h0000_2000, 2, 1'b0, '0, 1'b0);
    sendWord(32'h0000_0011, 2, 1'b1, 32'h2000, 1'b1);
    sendWord(32'h0000_0022, 2, 1'b1, 32'h2004, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_go_launch();
    sendGo(32'h0000_0200, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (pc_valid_o !== 1'b1 || pc_start_minus4 !== 32'h1FC) begin
      errors++;
      $display("FAIL run_hold pc_valid=%b pc_m4=%h ; expected 1 000001fc", pc_valid_o, pc_start_minus4);
    end
    sendPacket(1'b0, 32'h0000_0300, 1, 0);
  endtask

  task automatic test_err();
    sendWord(32'h5500_0000, 0, 1'b0, '0, 1'b0);
    expErr = 1;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL err_set err=%b busy=%b ; expected 1 0", err_o, busy_o);
    end
    sendPacket(1'b0, 32'h0000_0400, 3, 1);
  endtask

  task automatic test_zero_wrap();
    sendWord(32'h4900_0000, 0, 1'b0, '0, 1'b0);
    sendWord(32'h0000_0040, 0, 1'b0, '0, 1'b0);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_count_busy busy=%b expected 0", busy_o);
    end
    sendPacket(1'b0, 32'hFFFF_FFFC, 2, 0);
    sendPacket(1'b1, 32'hFFFF_FFF8, 3, 1);
  endtask

  task automatic test_random();
    logic [7:0] t;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 9))
        0, 1: sendGo($urandom & 32'hFFFF_FFFC, 2);
        2: begin
          t = 8'($urandom);
          while (t == 8'h49 || t == 8'h44 || t == 8'h47) t = 8'($urandom);
          sendWord({t, 24'($urandom)}, $urandom_range(0, 2), 1'b0, '0, 1'b0);
          expErr = 1;
          checks++;
          if (err_o !== 1'b1 || pc_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rand_unknown type=%h err=%b pcv=%b busy=%b ; expected 1 0 0", t, err_o, pc_valid_o, busy_o);
          end
        end
        default: sendPacket($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 6), 2);
      endcase
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    sendWord(32'h4900_0003, 0, 1'b0, '0, 1'b0);
    sendWord(32'h0000_0500, 0, 1'b0, '0, 1'b0);
    sendWord(32'h0000_00A1, 0, 1'b1, 32'h500, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h0000_00A2;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expQ.delete();
    expErr = 0;
    #1;
    checks++;
    if (imem_wr_valid !== 0 || dmem_wr_valid !== 0 || pc_valid_o !== 0 ||
        pc_start_minus4 !== 0 || busy_o !== 0 || err_o !== 0) begin
      errors++;
      $display("FAIL reset_mid imem=%b dmem=%b pcv=%b pcm4=%h busy=%b err=%b ; expected all 0",
               imem_wr_valid, dmem_wr_valid, pc_valid_o, pc_start_minus4, busy_o, err_o);
    end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset s_ready=%b expected 1", s_ready);
    end
    sendWord(32'h0000_000B, 0, 1'b0, '0, 1'b0);
    expErr = 1;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_word_header err=%b busy=%b ; expected 1 0", err_o, busy_o);
    end
    sendPacket(1'b1, 32'h0000_0600, 2, 1);
  endtask

  initial begin
    test_reset();
    test_imem_burst();
    test_dmem_gaps();
    test_go_launch();
    test_err();
    test_zero_wrap();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain pending_writes=%0d expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
